// File: rtl/modq_pkg.sv
// Shared constants and helpers for the q=3329 (Kyber) modular arithmetic blocks.
package modq_pkg;

  localparam int unsigned Q      = 3329;
  localparam int unsigned MU     = 5039;
  localparam int unsigned SHIFT  = 12;

  localparam int unsigned W_COEF = 12;
  localparam int unsigned W_PROD = 24;
  localparam int unsigned W_RED  = 14;
  localparam int unsigned W_H    = 25;
  localparam int unsigned W_T    = 13;
  localparam int unsigned W_DIFF = 25;

  // One conditional subtraction step; the building block of the final correction.
  function automatic logic [W_RED-1:0] condSub(input logic [W_RED-1:0] x,
                                               input logic [W_RED-1:0] m);
    return (x >= m) ? (x - m) : x;
  endfunction

endpackage

// File: rtl/barrett_corr_3329.sv
// Final Barrett correction: maps a partial residue r < 4q onto the canonical range [0,q).
module barrett_corr_3329
  import modq_pkg::*;
(
  input  logic [W_RED-1:0]  i_r,
  output logic [W_COEF-1:0] o_res
);

  localparam logic [W_RED-1:0] Q_RED = W_RED'(Q);

  logic [W_RED-1:0] w_sub1;
  logic [W_RED-1:0] w_sub2;
  logic [W_RED-1:0] w_sub3;
  logic             w_unusedHigh;

  // Three chained compares cover the worst case r in [3q, 4q).
  assign w_sub1 = condSub(i_r, Q_RED);
  assign w_sub2 = condSub(w_sub1, Q_RED);
  assign w_sub3 = condSub(w_sub2, Q_RED);

  assign o_res        = w_sub3[W_COEF-1:0];
  assign w_unusedHigh = ^w_sub3[W_RED-1:W_COEF];

endmodule

// File: rtl/modmul_3329_pipe.sv
// Streaming 12x12 modular multiplier mod 3329: four-stage Barrett pipeline with a global stall enable.
module modmul_3329_pipe
  import modq_pkg::W_COEF, modq_pkg::W_PROD, modq_pkg::W_RED,
         modq_pkg::W_H, modq_pkg::W_T, modq_pkg::W_DIFF;
#(
  parameter int unsigned Q     = modq_pkg::Q,
  parameter int unsigned MU    = modq_pkg::MU,
  parameter int unsigned SHIFT = modq_pkg::SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_COEF-1:0] din_a,
  input  logic [W_COEF-1:0] din_b,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [W_COEF-1:0] dout_r,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy
);

  logic              w_stall;
  logic              w_en;
  logic [W_PROD-1:0] w_prod;
  logic [W_COEF-1:0] w_q1;
  logic [W_T-1:0]    w_t;
  logic [W_DIFF-1:0] w_tq;
  logic [W_DIFF-1:0] w_diff;
  logic [W_COEF-1:0] w_corr;
  logic              w_unusedBits;

  logic [W_PROD-1:0] r_s1_p;
  logic              r_s1_v;
  logic [W_H-1:0]    r_s2_h;
  logic [W_PROD-1:0] r_s2_p;
  logic              r_s2_v;
  logic [W_RED-1:0]  r_s3_r;
  logic              r_s3_v;
  logic [W_COEF-1:0] r_dout_r;
  logic              r_dout_valid;

  // A held output freezes every stage, so no item can overtake or overwrite another.
  assign w_stall   = r_dout_valid & ~dout_ready;
  assign w_en      = ~w_stall;
  assign din_ready = ~w_stall & ~rst;

  assign w_prod = W_PROD'(din_a) * W_PROD'(din_b);
  assign w_q1   = r_s1_p[W_PROD-1:SHIFT];
  assign w_t    = r_s2_h[W_H-1:SHIFT];
  assign w_tq   = W_DIFF'(w_t) * W_DIFF'(Q);
  assign w_diff = W_DIFF'(r_s2_p) - w_tq;

  // Dropped low/high bits are by construction of the Barrett split; they carry no information.
  assign w_unusedBits = ^{r_s2_h[SHIFT-1:0], w_diff[W_DIFF-1:W_RED]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_p <= '0;
      r_s1_v <= 1'b0;
    end else if (w_en) begin
      r_s1_p <= w_prod;
      r_s1_v <= din_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_h <= '0;
      r_s2_p <= '0;
      r_s2_v <= 1'b0;
    end else if (w_en) begin
      r_s2_h <= W_H'(w_q1) * W_H'(MU);
      r_s2_p <= r_s1_p;
      r_s2_v <= r_s1_v;
    end
  end

  // Quotient estimate undershoots by at most 3, so the 14-bit partial residue stays below 4q.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3_r <= '0;
      r_s3_v <= 1'b0;
    end else if (w_en) begin
      r_s3_r <= w_diff[W_RED-1:0];
      r_s3_v <= r_s2_v;
    end
  end

  barrett_corr_3329 u_corr (
    .i_r   (r_s3_r),
    .o_res (w_corr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_r     <= '0;
      r_dout_valid <= 1'b0;
    end else if (w_en) begin
      r_dout_r     <= w_corr;
      r_dout_valid <= r_s3_v;
    end
  end

  assign dout_r     = r_dout_r;
  assign dout_valid = r_dout_valid;
  assign busy       = r_s1_v | r_s2_v | r_s3_v | r_dout_valid;

endmodule

// File: tb/tb_modmul_3329_pipe.sv
// Scoreboard bench for modmul_3329_pipe: directed corner cases, streaming, random stalls, mid-flight reset.
module tb_modmul_3329_pipe;

  typedef struct {
    int val;
    int stamp;
  } sbEntry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] din_a;
  logic [11:0] din_b;
  logic        din_valid;
  logic        din_ready;
  logic [11:0] dout_r;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;

  int          compared   = 0;
  int          mismatched = 0;
  int          cycCount   = 0;
  int          expOverride = -1;
  bit          checkLatency = 1'b1;
  bit          prevStall = 1'b0;
  logic [11:0] prevDout = '0;
  sbEntry_t    sb[$];

  modmul_3329_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .din_a      (din_a),
    .din_b      (din_b),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout_r     (dout_r),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic int golden(input int a, input int b);
    return (a * b) % 3329;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs are set now, outputs are scored at the falling edge, then the rising edge commits.
  task automatic applyStimulus(input logic [11:0] a, input logic [11:0] b,
                               input logic v, input logic rdy);
    sbEntry_t e;
    din_a      = a;
    din_b      = b;
    din_valid  = v;
    dout_ready = rdy;
    @(negedge clk);
    if (rst) begin
      checkOutput("dinReadyInReset", din_ready, 0);
      prevStall = 1'b0;
    end else begin
      checkOutput("dinReady", din_ready, !(dout_valid && !dout_ready));
      if (prevStall) begin
        checkOutput("holdValid", dout_valid, 1);
        checkOutput("holdData", dout_r, prevDout);
      end
      if (dout_valid && dout_ready) begin
        checkOutput("sbNonEmpty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("result", dout_r, e.val);
          if (checkLatency) checkOutput("latency", cycCount - e.stamp, 4);
        end
      end
      if (din_valid && din_ready) begin
        e.val   = (expOverride >= 0) ? expOverride : golden(int'(a), int'(b));
        e.stamp = cycCount;
        sb.push_back(e);
      end
      prevStall = dout_valid && !dout_ready;
      prevDout  = dout_r;
    end
    @(posedge clk);
    cycCount++;
    #1;
  endtask

  int dirA[5]   = '{3328, 4095, 0,    1,    3329};
  int dirB[5]   = '{3328, 4095, 1234, 3328, 1};
  int dirExp[5] = '{1,    852,  0,    3328, 0};

  initial begin
    rst        = 1'b1;
    din_a      = '0;
    din_b      = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) applyStimulus(12'd0, 12'd0, 1'b0, 1'b1);
    checkOutput("resetDoutValid", dout_valid, 0);
    checkOutput("resetDoutR", dout_r, 0);
    checkOutput("resetBusy", busy, 0);
    rst = 1'b0;

    $display("[TB] directed corner cases");
    for (int i = 0; i < 5; i++) begin
      expOverride = dirExp[i];
      applyStimulus(12'(dirA[i]), 12'(dirB[i]), 1'b1, 1'b1);
      expOverride = -1;
      for (int k = 0; k < 6; k++) applyStimulus(12'd0, 12'd0, 1'b0, 1'b1);
    end
    checkOutput("directedDrained", sb.size(), 0);

    $display("[TB] back-to-back stream");
    for (int i = 0; i < 1000; i++)
      applyStimulus(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) applyStimulus(12'd0, 12'd0, 1'b0, 1'b1);
    checkOutput("streamDrained", sb.size(), 0);
    checkOutput("streamIdleBusy", busy, 0);

    $display("[TB] random valid and ready");
    checkLatency = 1'b0;
    for (int i = 0; i < 1500; i++)
      applyStimulus(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int k = 0; k < 10; k++) applyStimulus(12'd0, 12'd0, 1'b0, 1'b1);
    checkOutput("randomDrained", sb.size(), 0);
    checkLatency = 1'b1;

    $display("[TB] reset with items in flight");
    applyStimulus(12'd100, 12'd200, 1'b1, 1'b1);
    applyStimulus(12'd4000, 12'd17, 1'b1, 1'b1);
    applyStimulus(12'd3000, 12'd3000, 1'b1, 1'b1);
    checkOutput("busyInFlight", busy, 1);
    rst = 1'b1;
    applyStimulus(12'd0, 12'd0, 1'b0, 1'b1);
    sb.delete();
    rst = 1'b0;
    checkOutput("postResetDoutValid", dout_valid, 0);
    checkOutput("postResetBusy", busy, 0);
    expOverride = 6;
    applyStimulus(12'd2, 12'd3, 1'b1, 1'b1);
    expOverride = -1;
    for (int k = 0; k < 8; k++) applyStimulus(12'd0, 12'd0, 1'b0, 1'b1);
    checkOutput("postResetDrained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
